// File: rtl/uart_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : uart_bus_pkg                                                  |
// | Description : Shared types and constants for the UART register-bus         |
// |               arbiter and its bus-cycle generator.                        |
// |   busState_t    - bus-cycle FSM states (IDLE/SETUP/STROBE/HOLD)            |
// |   c_cntWidth    - width of the phase cycle counter                          |
// |   c_cycMin/Max  - legal range for the SETUP/STROBE phase lengths           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package uart_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } busState_t;

  localparam int c_cntWidth = 4;
  localparam int c_cycMin   = 1;
  localparam int c_cycMax   = 15;

endpackage
`default_nettype wire

// File: rtl/uart_bus_cycle_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_bus_cycle_gen                                            |
// | Description : Timed UART register-bus cycle: SETUP -> STROBE -> HOLD.      |
// |               Latches the transaction at start and drives registered      |
// |               chip select, strobes, address and write data.               |
// | Ports       : clk, rst (sync, active-low)                                   |
// |               start/we/addr/wdata - transaction request (sampled in IDLE)  |
// |               done  - high in the final STROBE cycle                        |
// |               rdata - read data, valid while done is high                   |
// |               addrBus/nChipSelect/nRd/nWe/dataBusOut/dataBusIn - core bus  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_bus_cycle_gen
  import uart_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic [3:0] addrBus,
  output logic       nChipSelect,
  output logic       nRd,
  output logic       nWe,
  output logic [7:0] dataBusOut,
  input  logic [7:0] dataBusIn
);

  if (SETUP_CYC < c_cycMin || SETUP_CYC > c_cycMax) begin : g_badSetupCyc
    $error("uart_bus_cycle_gen: SETUP_CYC out of range 1..15");
  end
  if (STROBE_CYC < c_cycMin || STROBE_CYC > c_cycMax) begin : g_badStrobeCyc
    $error("uart_bus_cycle_gen: STROBE_CYC out of range 1..15");
  end

  localparam logic [c_cntWidth-1:0] c_setupLoad  = c_cntWidth'(SETUP_CYC - 1);
  localparam logic [c_cntWidth-1:0] c_strobeLoad = c_cntWidth'(STROBE_CYC - 1);

  busState_t              r_state, w_nextState;
  logic [c_cntWidth-1:0]  r_cnt, w_nextCnt;
  logic                   r_we;
  logic [3:0]             r_addr;
  logic [7:0]             r_wdata;
  logic                   w_txnWe;
  logic [3:0]             w_txnAddr;
  logic [7:0]             w_txnWdata;
  logic                   w_nextCs, w_nextRd, w_nextWr;
  logic [3:0]             w_nextAddr;
  logic [7:0]             w_nextData;

  // Read data is sampled straight off the core bus at the edge closing the
  // last strobe cycle; the arbiter registers it there.
  assign done  = (r_state == ST_STROBE) && (r_cnt == '0);
  assign rdata = dataBusIn;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    // In IDLE the transaction registers are not loaded yet, so the first
    // SETUP cycle's bus values come straight from the request inputs.
    w_txnWe     = r_we;
    w_txnAddr   = r_addr;
    w_txnWdata  = r_wdata;
    if (r_state == ST_IDLE) begin
      w_txnWe    = we;
      w_txnAddr  = addr;
      w_txnWdata = wdata;
    end

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = ST_SETUP;
          w_nextCnt   = c_setupLoad;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_nextState = ST_STROBE;
          w_nextCnt   = c_strobeLoad;
        end else begin
          w_nextCnt = r_cnt - 1'b1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_nextState = ST_HOLD;
        end else begin
          w_nextCnt = r_cnt - 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase

    // Bus outputs are registered, so decode them from the state being entered.
    w_nextCs   = 1'b1;
    w_nextRd   = 1'b1;
    w_nextWr   = 1'b1;
    w_nextAddr = 4'h0;
    w_nextData = 8'h00;
    if (w_nextState != ST_IDLE) begin
      w_nextCs   = 1'b0;
      w_nextAddr = w_txnAddr;
      w_nextData = w_txnWe ? w_txnWdata : 8'h00;
    end
    if (w_nextState == ST_STROBE) begin
      w_nextRd = w_txnWe;
      w_nextWr = !w_txnWe;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= 4'h0;
      r_wdata     <= 8'h00;
      nChipSelect <= 1'b1;
      nRd         <= 1'b1;
      nWe         <= 1'b1;
      addrBus     <= 4'h0;
      dataBusOut  <= 8'h00;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      if (r_state == ST_IDLE && start) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      nChipSelect <= w_nextCs;
      nRd         <= w_nextRd;
      nWe         <= w_nextWr;
      addrBus     <= w_nextAddr;
      dataBusOut  <= w_nextData;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_bus_arbiter                                              |
// | Description : Round-robin arbiter sharing the UART core register bus       |
// |               between two requesters; runs one timed bus cycle per grant  |
// |               and returns a one-cycle ack plus read data.                 |
// | Ports       : clk, rst (sync, active-low)                                   |
// |               reqN_i/weN_i/addrN_i/wdataN_i - requester N transaction      |
// |               ackN_o/rdataN_o               - requester N completion       |
// |               AddrBus_o/n_ChipSelect_o/n_rd_o/n_we_o/DataBus_o/DataBus_i   |
// |                                             - UART core bus               |
// |               gnt_o  - one-hot grant, busy_o - transaction in progress     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_bus_arbiter
  import uart_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_i,
  input  logic       we0_i,
  input  logic [3:0] addr0_i,
  input  logic [7:0] wdata0_i,
  output logic       ack0_o,
  output logic [7:0] rdata0_o,
  input  logic       req1_i,
  input  logic       we1_i,
  input  logic [3:0] addr1_i,
  input  logic [7:0] wdata1_i,
  output logic       ack1_o,
  output logic [7:0] rdata1_o,
  output logic [3:0] AddrBus_o,
  output logic       n_ChipSelect_o,
  output logic       n_rd_o,
  output logic       n_we_o,
  output logic [7:0] DataBus_o,
  input  logic [7:0] DataBus_i,
  output logic [1:0] gnt_o,
  output logic       busy_o
);

  logic       r_ptr;      // requester that wins when both ask
  logic       r_isRead;
  logic       w_start, w_pick1, w_we, w_done;
  logic [3:0] w_addr;
  logic [7:0] w_wdata, w_rdata;

  assign w_start = !busy_o && (req0_i || req1_i);
  assign w_pick1 = req1_i && (!req0_i || r_ptr);
  assign w_we    = w_pick1 ? we1_i    : we0_i;
  assign w_addr  = w_pick1 ? addr1_i  : addr0_i;
  assign w_wdata = w_pick1 ? wdata1_i : wdata0_i;

  uart_bus_cycle_gen #(
    .SETUP_CYC  (SETUP_CYC),
    .STROBE_CYC (STROBE_CYC)
  ) u_cycleGen (
    .clk         (clk),
    .rst         (rst),
    .start       (w_start),
    .we          (w_we),
    .addr        (w_addr),
    .wdata       (w_wdata),
    .done        (w_done),
    .rdata       (w_rdata),
    .addrBus     (AddrBus_o),
    .nChipSelect (n_ChipSelect_o),
    .nRd         (n_rd_o),
    .nWe         (n_we_o),
    .dataBusOut  (DataBus_o),
    .dataBusIn   (DataBus_i)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr    <= 1'b0;
      r_isRead <= 1'b0;
      gnt_o    <= 2'b00;
      busy_o   <= 1'b0;
      ack0_o   <= 1'b0;
      ack1_o   <= 1'b0;
      rdata0_o <= 8'h00;
      rdata1_o <= 8'h00;
    end else begin
      ack0_o <= 1'b0;
      ack1_o <= 1'b0;
      if (w_start) begin
        gnt_o    <= w_pick1 ? 2'b10 : 2'b01;
        busy_o   <= 1'b1;
        r_isRead <= !w_we;
      end else if (ack0_o || ack1_o) begin
        // The ack cycle is HOLD; the bus returns to IDLE at this edge.
        gnt_o  <= 2'b00;
        busy_o <= 1'b0;
      end
      if (w_done) begin
        ack0_o <= gnt_o[0];
        ack1_o <= gnt_o[1];
        r_ptr  <= gnt_o[0];   // hand priority to the port not just served
        if (r_isRead && gnt_o[0]) rdata0_o <= w_rdata;
        if (r_isRead && gnt_o[1]) rdata1_o <= w_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_bus_arbiter                                           |
// | Description : Directed self-checking bench for uart_bus_arbiter with       |
// |               default timing (SETUP_CYC=1, STROBE_CYC=2).                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic [3:0] addrBus;
  logic       nCs, nRd, nWe;
  logic [7:0] dataOut, dataIn;
  logic [1:0] gnt;
  logic       busy;

  int vecCnt = 0;
  int errCnt = 0;

  // per-window bus statistics
  int         csLow, weLow, rdLow, ack0Cnt, ack1Cnt, ack0At, ack1At;
  int         nGnt, minGap, highRun;
  logic       prevCs, hadTxn;
  logic [1:0] prevGnt;
  logic [1:0] gntSeq [8];
  logic [3:0] strobeAddr;
  logic [7:0] strobeData, rdata0AtAck, rdata1AtAck, rdPattern;

  uart_bus_arbiter #(.SETUP_CYC(1), .STROBE_CYC(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_i         (req0),
    .we0_i          (we0),
    .addr0_i        (addr0),
    .wdata0_i       (wdata0),
    .ack0_o         (ack0),
    .rdata0_o       (rdata0),
    .req1_i         (req1),
    .we1_i          (we1),
    .addr1_i        (addr1),
    .wdata1_i       (wdata1),
    .ack1_o         (ack1),
    .rdata1_o       (rdata1),
    .AddrBus_o      (addrBus),
    .n_ChipSelect_o (nCs),
    .n_rd_o         (nRd),
    .n_we_o         (nWe),
    .DataBus_o      (dataOut),
    .DataBus_i      (dataIn),
    .gnt_o          (gnt),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chkVec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearStats();
    csLow = 0; weLow = 0; rdLow = 0;
    ack0Cnt = 0; ack1Cnt = 0; ack0At = 0; ack1At = 0;
    nGnt = 0; minGap = 99; highRun = 0; hadTxn = 1'b0;
    prevCs = nCs; prevGnt = gnt;
    strobeAddr = 4'h0; strobeData = 8'h00;
    rdata0AtAck = 8'h00; rdata1AtAck = 8'h00;
    for (int i = 0; i < 8; i++) gntSeq[i] = 2'b00;
  endtask

  // Steps nCyc clocks gathering bus statistics; both requests are dropped
  // once dropAfter acks in total have been seen. The core drives rdPattern
  // only while the read strobe is low.
  task automatic observe(input int nCyc, input int dropAfter);
    for (int c = 1; c <= nCyc; c++) begin
      step();
      if (!nCs) csLow++;
      if (!nWe) begin weLow++; strobeAddr = addrBus; strobeData = dataOut; end
      if (!nRd) begin rdLow++; strobeAddr = addrBus; end
      dataIn = !nRd ? rdPattern : 8'h00;
      if (gnt != 2'b00 && prevGnt == 2'b00 && nGnt < 8) begin
        gntSeq[nGnt] = gnt;
        nGnt++;
      end
      prevGnt = gnt;
      if (!nCs && prevCs) begin
        if (hadTxn && highRun < minGap) minGap = highRun;
        hadTxn  = 1'b1;
        highRun = 0;
      end
      if (nCs) highRun++;
      prevCs = nCs;
      if (ack0) begin ack0Cnt++; ack0At = c; rdata0AtAck = rdata0; end
      if (ack1) begin ack1Cnt++; ack1At = c; rdata1AtAck = rdata1; end
      if (ack0Cnt + ack1Cnt == dropAfter) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  initial begin
    rst = 1'b0; dataIn = 8'h00; rdPattern = 8'h00;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 8'hA5;
    req1 = 1'b0; we1 = 1'b0; addr1 = 4'h0; wdata1 = 8'h00;

    // reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      step();
      chkVec("rst_strobes", {nCs, nRd, nWe}, 3'b111);
      chkVec("rst_ack", {ack0, ack1}, 2'b00);
      chkVec("rst_gnt", {busy, gnt}, 3'b000);
    end
    rst = 1'b1;

    // single write from port 0, served first after release
    clearStats();
    observe(6, 1);
    chkVec("wr_gnt", gntSeq[0], 2'b01);
    chkVec("wr_ackCnt", ack0Cnt, 1);
    chkVec("wr_ackAt", ack0At, 4);
    chkVec("wr_csLow", csLow, 4);
    chkVec("wr_weLow", weLow, 2);
    chkVec("wr_rdLow", rdLow, 0);
    chkVec("wr_addr", strobeAddr, 4'h3);
    chkVec("wr_data", strobeData, 8'hA5);
    chkVec("wr_ack1", ack1Cnt, 0);
    chkVec("wr_idle", {nCs, busy, gnt}, 4'b1000);

    // single read from port 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h8; rdPattern = 8'h5C;
    clearStats();
    observe(6, 1);
    chkVec("rd_gnt", gntSeq[0], 2'b10);
    chkVec("rd_ackCnt", ack1Cnt, 1);
    chkVec("rd_ackAt", ack1At, 4);
    chkVec("rd_rdLow", rdLow, 2);
    chkVec("rd_weLow", weLow, 0);
    chkVec("rd_addr", strobeAddr, 4'h8);
    chkVec("rd_rdata1", rdata1AtAck, 8'h5C);
    chkVec("rd_rdata0", rdata0, 8'h00);
    chkVec("rd_ack0", ack0Cnt, 0);

    // contention: four transactions alternate starting with port 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h1; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2; rdPattern = 8'hC3;
    clearStats();
    observe(30, 4);
    chkVec("cont_nGnt", nGnt, 4);
    chkVec("cont_seq", {gntSeq[0], gntSeq[1], gntSeq[2], gntSeq[3]}, 8'b01_10_01_10);
    chkVec("cont_gap", minGap, 1);
    chkVec("cont_acks", {ack0Cnt[3:0], ack1Cnt[3:0]}, 8'h22);
    chkVec("cont_rdata1", rdata1, 8'hC3);

    // withdrawal after grant with fields changed
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h6; wdata0 = 8'h3C;
    clearStats();
    observe(1, 99);
    req0 = 1'b0; addr0 = 4'hF; wdata0 = 8'hFF;
    observe(8, 99);
    chkVec("wd_ack", ack0Cnt, 1);
    chkVec("wd_addr", strobeAddr, 4'h6);
    chkVec("wd_data", strobeData, 8'h3C);
    chkVec("wd_csLow", csLow, 4);
    chkVec("wd_nGnt", nGnt, 1);

    // reset during the write strobe; port 0 was served last
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h9; wdata0 = 8'h77;
    for (int i = 0; i < 10 && nWe === 1'b1; i++) step();
    chkVec("mid_strobeReached", nWe, 1'b0);
    req0 = 1'b0;
    rst = 1'b0;
    step();
    chkVec("mid_strobes", {nCs, nRd, nWe}, 3'b111);
    chkVec("mid_ack", {ack0, ack1}, 2'b00);
    chkVec("mid_gnt", {busy, gnt}, 3'b000);
    step();
    chkVec("mid_ack2", {ack0, ack1}, 2'b00);
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 4'hA;
    rst = 1'b1;
    clearStats();
    observe(15, 2);
    chkVec("post_nGnt", nGnt, 2);
    chkVec("post_seq", {gntSeq[0], gntSeq[1]}, 4'b01_10);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
`default_nettype wire
